// File: rtl/inst_trace_fifo_if.sv
// Byte-wide valid/ready stream carrying trace frames toward the UART/debug link.
interface inst_trace_fifo_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;

    modport master (output out_valid, output out_byte, input out_ready);
    modport slave  (input out_valid, input out_byte, output out_ready);
endinterface

// File: rtl/inst_trace_fifo.sv
// Captures pc/inst pairs into a FIFO and serializes each entry as a 9-byte frame
// (A5 sync, pc MSB first, inst MSB first); captures that find the FIFO full are counted as drops.
//
// state | meaning
// IDLE  | no frame in flight, out_valid low
// SEND  | presenting frame byte idx, advancing on each accepted byte
module inst_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic [31:0]             pc,
    input  logic [31:0]             inst,
    input  logic                    cap_en,
    inst_trace_fifo_if.master       out_if,
    output logic [AW:0]             fifo_count,
    output logic [15:0]             drop_cnt
);
    typedef enum logic [0:0] {IDLE, SEND} state_t;

    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [63:0]     frame_q, frame_d;
    logic            valid_q, valid_d;
    logic [7:0]      byte_q, byte_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [15:0]     drop_q, drop_d;
    logic [63:0]     mem_q [DEPTH];
    logic            push, pop;

    function automatic logic [7:0] frame_byte(input logic [63:0] f, input logic [3:0] k);
        case (k)
            4'd0:    frame_byte = 8'hA5;
            4'd1:    frame_byte = f[63:56];
            4'd2:    frame_byte = f[55:48];
            4'd3:    frame_byte = f[47:40];
            4'd4:    frame_byte = f[39:32];
            4'd5:    frame_byte = f[31:24];
            4'd6:    frame_byte = f[23:16];
            4'd7:    frame_byte = f[15:8];
            4'd8:    frame_byte = f[7:0];
            default: frame_byte = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        valid_d  = valid_q;
        byte_d   = byte_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) pop = 1'b1;
            end
            SEND: begin
                if (out_if.out_ready) begin
                    if (idx_q != 4'd8) begin
                        idx_d  = idx_q + 4'd1;
                        byte_d = frame_byte(frame_q, idx_q + 4'd1);
                    end else if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        byte_d  = 8'h00;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Loading the head also starts the frame, so byte 0 is always the sync.
        if (pop) begin
            frame_d  = mem_q[rd_ptr_q];
            idx_d    = 4'd0;
            state_d  = SEND;
            valid_d  = 1'b1;
            byte_d   = 8'hA5;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        push = cap_en && ((count_q != DEPTH_C) || pop);
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (cap_en && !push && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            frame_q  <= 64'd0;
            valid_q  <= 1'b0;
            byte_q   <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
            byte_q   <= byte_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_in) begin
        if (push && !reset) mem_q[wr_ptr_q] <= {pc, inst};
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_byte  = byte_q;
    assign fifo_count       = count_q;
    assign drop_cnt         = drop_q;
endmodule

// File: tb/tb_inst_trace_fifo.sv
// Directed bench for inst_trace_fifo: a vector table for the basic frame plus
// hand-written sequences for backpressure, overflow, full push/pop, reset and drop saturation.
module tb_inst_trace_fifo;
    logic        clk_in;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        cap_en;
    logic [4:0]  fifo_count;
    logic [15:0] drop_cnt;

    inst_trace_fifo_if bus ();

    inst_trace_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .pc         (pc),
        .inst       (inst),
        .cap_en     (cap_en),
        .out_if     (bus),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rst;
        logic        cap;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rdy;
        logic        e_valid;
        logic [7:0]  e_byte;
        logic [4:0]  e_count;
        logic [15:0] e_drop;
    } vec_t;

    vec_t       vecs [12];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] got [$];
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cap_en = 1'b0; bus.out_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic add_frame(input logic [31:0] p, input logic [31:0] i);
        exp_q.push_back(8'hA5);
        exp_q.push_back(p[31:24]); exp_q.push_back(p[23:16]);
        exp_q.push_back(p[15:8]);  exp_q.push_back(p[7:0]);
        exp_q.push_back(i[31:24]); exp_q.push_back(i[23:16]);
        exp_q.push_back(i[15:8]);  exp_q.push_back(i[7:0]);
    endtask

    task automatic drain(input int nbytes, input bit bp, input int budget, output int cycles);
        int   c = 0;
        bit   prev_stall = 1'b0;
        logic [7:0] prev_byte = 8'h00;
        cap_en = 1'b0;
        while (got.size() < nbytes && c < budget) begin
            bus.out_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            if (prev_stall) begin
                chk("hold_byte", {24'd0, bus.out_byte}, {24'd0, prev_byte});
                chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            end
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_byte);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_byte  = bus.out_byte;
            step();
            c++;
        end
        cycles = c;
        if (got.size() < nbytes) chk("drain_timeout", got.size(), nbytes);
    endtask

    task automatic cmp_stream(input string name);
        chk({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(name, {24'd0, got[i]}, {24'd0, exp_q[i]});
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        reset = 1'b1; cap_en = 1'b0; pc = 32'd0; inst = 32'd0; bus.out_ready = 1'b0;

        // Reset, single capture, then the nine frame bytes and the return to idle.
        vecs[0]  = '{1, 0, 32'h0,        32'h0,        1, 0, 8'h00, 0, 0};
        vecs[1]  = '{0, 1, 32'h00400000, 32'h3C011001, 1, 0, 8'h00, 1, 0};
        vecs[2]  = '{0, 0, 32'h0,        32'h0,        1, 1, 8'hA5, 0, 0};
        vecs[3]  = '{0, 0, 32'h0,        32'h0,        1, 1, 8'h00, 0, 0};
        vecs[4]  = '{0, 0, 32'h0,        32'h0,        1, 1, 8'h40, 0, 0};
        vecs[5]  = '{0, 0, 32'h0,        32'h0,        1, 1, 8'h00, 0, 0};
        vecs[6]  = '{0, 0, 32'h0,        32'h0,        1, 1, 8'h00, 0, 0};
        vecs[7]  = '{0, 0, 32'h0,        32'h0,        1, 1, 8'h3C, 0, 0};
        vecs[8]  = '{0, 0, 32'h0,        32'h0,        1, 1, 8'h01, 0, 0};
        vecs[9]  = '{0, 0, 32'h0,        32'h0,        1, 1, 8'h10, 0, 0};
        vecs[10] = '{0, 0, 32'h0,        32'h0,        1, 1, 8'h01, 0, 0};
        vecs[11] = '{0, 0, 32'h0,        32'h0,        1, 0, 8'h00, 0, 0};

        for (int v = 0; v < 12; v++) begin
            reset = vecs[v].rst; cap_en = vecs[v].cap; pc = vecs[v].pc;
            inst = vecs[v].inst; bus.out_ready = vecs[v].rdy;
            step();
            chk("vec_valid", {31'd0, bus.out_valid}, {31'd0, vecs[v].e_valid});
            if (vecs[v].e_valid || vecs[v].rst)
                chk("vec_byte", {24'd0, bus.out_byte}, {24'd0, vecs[v].e_byte});
            chk("vec_count", {27'd0, fifo_count}, {27'd0, vecs[v].e_count});
            chk("vec_drop", {16'd0, drop_cnt}, {16'd0, vecs[v].e_drop});
        end

        // Backpressure: ready pattern 1,0,0,1 repeating.
        do_reset();
        cap_en = 1'b1; pc = 32'h00400000; inst = 32'h3C011001;
        step();
        add_frame(32'h00400000, 32'h3C011001);
        drain(9, 1'b1, 100, cyc);
        cmp_stream("bp_byte");

        // Overflow: 20 captures with link stalled.
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cap_en = 1'b1; pc = 32'h00400000 + 32'(4 * k); inst = 32'h0C000000 + 32'(k);
            step();
        end
        chk("ovf_count", {27'd0, fifo_count}, 32'd16);
        chk("ovf_drop", {16'd0, drop_cnt}, 32'd3);
        chk("ovf_valid", {31'd0, bus.out_valid}, 32'd1);
        for (int k = 0; k < 17; k++) add_frame(32'h00400000 + 32'(4 * k), 32'h0C000000 + 32'(k));
        drain(153, 1'b0, 400, cyc);
        chk("ovf_cycles", cyc, 32'd153);
        cmp_stream("ovf_byte");
        chk("ovf_idle_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("ovf_idle_count", {27'd0, fifo_count}, 32'd0);

        // Full FIFO: capture on the final-byte handshake is accepted.
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            cap_en = 1'b1; pc = 32'h10000000 + 32'(4 * k); inst = 32'hA0B0C0D0 + 32'(k);
            step();
        end
        chk("full_count", {27'd0, fifo_count}, 32'd16);
        chk("full_drop0", {16'd0, drop_cnt}, 32'd0);
        cap_en = 1'b0; bus.out_ready = 1'b1;
        repeat (8) step();
        chk("full_lastbyte", {24'd0, bus.out_byte}, 32'h000000D0);
        cap_en = 1'b1; pc = 32'h20000000; inst = 32'h11111111;
        step();
        chk("full_pp_count", {27'd0, fifo_count}, 32'd16);
        chk("full_pp_drop", {16'd0, drop_cnt}, 32'd0);
        chk("full_pp_byte", {24'd0, bus.out_byte}, 32'h000000A5);
        bus.out_ready = 1'b0;
        step();
        chk("full_drop1", {16'd0, drop_cnt}, 32'd1);
        chk("full_count2", {27'd0, fifo_count}, 32'd16);

        // Reset mid-frame after bytes 0..3 are accepted.
        cap_en = 1'b0; bus.out_ready = 1'b1;
        repeat (4) step();
        reset = 1'b1; cap_en = 1'b1;
        step();
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_byte", {24'd0, bus.out_byte}, 32'd0);
        chk("rst_count", {27'd0, fifo_count}, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
        reset = 1'b0; cap_en = 1'b0;
        step();
        chk("rst_nocap", {27'd0, fifo_count}, 32'd0);
        cap_en = 1'b1; pc = 32'hCAFEBAB0; inst = 32'h12345678;
        step();
        add_frame(32'hCAFEBAB0, 32'h12345678);
        drain(9, 1'b0, 50, cyc);
        cmp_stream("rst_frame");

        // Drop saturation: 70000 drops.
        do_reset();
        bus.out_ready = 1'b0; cap_en = 1'b1; pc = 32'h0; inst = 32'h0;
        repeat (17) step();
        chk("sat_start", {16'd0, drop_cnt}, 32'd0);
        repeat (65534) step();
        chk("sat_fffe", {16'd0, drop_cnt}, 32'h0000FFFE);
        step();
        chk("sat_ffff", {16'd0, drop_cnt}, 32'h0000FFFF);
        repeat (4465) step();
        chk("sat_hold", {16'd0, drop_cnt}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
